// File: rtl/sysid_chk_pkg.sv
// sysid_chk_pkg: shared state encoding, slave word addresses and default
// expected values for the system-ID check controller.
`default_nettype none

package sysid_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_EVAL  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID_DEF = 32'hACD51302;
  localparam logic [31:0] SYSID_EXPECTED_TS_DEF = 32'h58AF95CD;

endpackage

`default_nettype wire

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: Avalon-MM read master that fetches system ID and build timestamp
// and compares both against synthesis-time values. Optional: SYSID_CHK_AUTOSTART_EN.
`default_nettype none

module sysid_check_ctrl
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID_DEF,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS_DEF,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TO_W           = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  state_e            r_state;
  state_e            w_next;
  logic [TO_W-1:0]   r_cnt;
  logic              r_pass;
  logic              r_id_mm;
  logic              r_ts_mm;
  logic              r_timeout;
  logic [31:0]       r_cap_id;
  logic [31:0]       r_cap_ts;
  logic              r_avm_read;
  logic              r_avm_addr;

  logic              w_start;
  logic              w_in_rd;
  logic              w_expired;

`ifdef SYSID_CHK_AUTOSTART_EN
  // One-shot start on the first clock after reset release.
  logic r_auto;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_auto <= 1'b1;
    else          r_auto <= 1'b0;
  end
  assign w_start = start | r_auto;
`else
  assign w_start = start;
`endif

  assign w_in_rd   = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  // Abort only once the full stall budget is spent and the slave still stalls.
  assign w_expired = (r_cnt == TO_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_RD_ID;
      end
      ST_RD_ID: begin
        if (!avm_waitrequest) w_next = ST_RD_TS;
        else if (w_expired)   w_next = ST_FIN;
      end
      ST_RD_TS: begin
        if (!avm_waitrequest) w_next = ST_EVAL;
        else if (w_expired)   w_next = ST_FIN;
      end
      ST_EVAL: w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_avm_read <= 1'b0;
      r_avm_addr <= SYSID_ADDR_ID;
    end else begin
      r_state    <= w_next;
      r_avm_read <= (w_next == ST_RD_ID) || (w_next == ST_RD_TS);
      r_avm_addr <= (w_next == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      if (w_in_rd && avm_waitrequest && !w_expired) r_cnt <= r_cnt + TO_W'(1);
      else                                          r_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pass    <= 1'b0;
      r_id_mm   <= 1'b0;
      r_ts_mm   <= 1'b0;
      r_timeout <= 1'b0;
      r_cap_id  <= '0;
      r_cap_ts  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_pass    <= 1'b0;
            r_id_mm   <= 1'b0;
            r_ts_mm   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        ST_RD_ID: begin
          if (!avm_waitrequest) r_cap_id  <= avm_readdata;
          else if (w_expired)   r_timeout <= 1'b1;
        end
        ST_RD_TS: begin
          if (!avm_waitrequest) r_cap_ts  <= avm_readdata;
          else if (w_expired)   r_timeout <= 1'b1;
        end
        ST_EVAL: begin
          r_id_mm <= (r_cap_id != EXPECTED_ID);
          r_ts_mm <= (r_cap_ts != EXPECTED_TS);
          r_pass  <= (r_cap_id == EXPECTED_ID) && (r_cap_ts == EXPECTED_TS);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == ST_RD_ID) || (r_state == ST_RD_TS) || (r_state == ST_EVAL);
  assign done        = (r_state == ST_FIN);
  assign pass        = r_pass;
  assign id_mismatch = r_id_mm;
  assign ts_mismatch = r_ts_mm;
  assign timeout     = r_timeout;
  assign captured_id = r_cap_id;
  assign captured_ts = r_cap_ts;
  assign avm_read    = r_avm_read;
  assign avm_address = r_avm_addr;

endmodule

`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed self-checking bench; instance A uses the default
// timeout, instance B a 4-cycle timeout for abort/boundary cases.
`default_nettype none

module tb_sysid_check_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start_a, start_b;
  int          stall_len;
  logic [31:0] id_val, ts_val;
  int          n_cmp, n_bad;

  logic        busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a, addr_a, read_a, wr_a;
  logic [31:0] capid_a, capts_a, rd_a;
  logic        busy_b, done_b, pass_b, idmm_b, tsmm_b, to_b, addr_b, read_b, wr_b;
  logic [31:0] capid_b, capts_b, rd_b;
  int          sc_a, sc_b;

  sysid_check_ctrl u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .id_mismatch(idmm_a), .ts_mismatch(tsmm_a), .timeout(to_a),
    .captured_id(capid_a), .captured_ts(capts_a),
    .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wr_a), .avm_readdata(rd_a)
  );

  sysid_check_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(4)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .id_mismatch(idmm_b), .ts_mismatch(tsmm_b), .timeout(to_b),
    .captured_id(capid_b), .captured_ts(capts_b),
    .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wr_b), .avm_readdata(rd_b)
  );

  // Slave models: stall each read for stall_len cycles, then return the word.
  assign rd_a = addr_a ? ts_val : id_val;
  assign rd_b = addr_b ? ts_val : id_val;
  assign wr_a = read_a && (sc_a < stall_len);
  assign wr_b = read_b && (sc_b < stall_len);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)            sc_a <= 0;
    else if (read_a && wr_a) sc_a <= sc_a + 1;
    else                     sc_a <= 0;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)            sc_b <= 0;
    else if (read_b && wr_b) sc_b <= sc_b + 1;
    else                     sc_b <= 0;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_a(input int limit, output int cyc);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_b(input int limit, output int cyc, output bit ts_seen);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    ts_seen = 1'b0;
    while (done_b !== 1'b1 && cyc < limit) begin
      if (read_b === 1'b1 && addr_b === 1'b1) ts_seen = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic wait_auto_a(output int cyc);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    int cyc;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stall_len = 0;
    id_val = 32'hACD51302; ts_val = 32'h58AF95CD;
    repeat (2) tick();
    n_cmp++; if ({busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a, read_a, addr_a} !== 8'h00) begin
      n_bad++; $display("FAIL reset_flags_a: got %b want %b", {busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a, read_a, addr_a}, 8'h00); end
    n_cmp++; if ({capid_a, capts_a} !== 64'h0) begin
      n_bad++; $display("FAIL reset_captured_a: got %h want %h", {capid_a, capts_a}, 64'h0); end
    n_cmp++; if ({busy_b, done_b, pass_b, to_b, read_b} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags_b: got %b want %b", {busy_b, done_b, pass_b, to_b, read_b}, 5'b0); end
    reset_n = 1'b1;
`ifdef SYSID_CHK_AUTOSTART_EN
    wait_auto_a(cyc);
    n_cmp++; if ((done_a === 1'b1 && cyc <= 5) !== 1'b1) begin
      n_bad++; $display("FAIL autostart_done: got cycle %0d done %b want done within 5", cyc, done_a); end
    n_cmp++; if (pass_a !== 1'b1) begin
      n_bad++; $display("FAIL autostart_pass: got %b want 1", pass_a); end
    tick();
`else
    repeat (3) tick();
    cyc = 0;
    n_cmp++; if ({busy_a, read_a} !== 2'b00) begin
      n_bad++; $display("FAIL no_autostart: got %b want %b", {busy_a, read_a}, 2'b00); end
`endif
  endtask

  task automatic test_zero_wait;
    int cyc;
    run_a(20, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL zw_latency: got %0d want 4", cyc); end
    n_cmp++; if ({busy_a, pass_a, idmm_a, tsmm_a, to_a} !== 5'b01000) begin
      n_bad++; $display("FAIL zw_flags: got %b want %b", {busy_a, pass_a, idmm_a, tsmm_a, to_a}, 5'b01000); end
    n_cmp++; if (capts_a !== 32'h58AF95CD) begin n_bad++; $display("FAIL zw_capts: got %h want 58af95cd", capts_a); end
    n_cmp++; if (capid_a !== 32'hACD51302) begin n_bad++; $display("FAIL zw_capid: got %h want acd51302", capid_a); end
    tick();
    n_cmp++; if ({done_a, pass_a} !== 2'b01) begin
      n_bad++; $display("FAIL zw_done_pulse: got %b want %b", {done_a, pass_a}, 2'b01); end
  endtask

  task automatic test_mismatch;
    int cyc;
    id_val = 32'h00000001;
    run_a(20, cyc);
    n_cmp++; if ({pass_a, idmm_a, tsmm_a} !== 3'b010) begin
      n_bad++; $display("FAIL idmm_flags: got %b want %b", {pass_a, idmm_a, tsmm_a}, 3'b010); end
    n_cmp++; if (capid_a !== 32'h00000001) begin n_bad++; $display("FAIL idmm_capid: got %h want 00000001", capid_a); end
    tick();
    id_val = 32'hACD51302; ts_val = 32'hFFFFFFFF;
    run_a(20, cyc);
    n_cmp++; if ({pass_a, idmm_a, tsmm_a} !== 3'b001) begin
      n_bad++; $display("FAIL tsmm_flags: got %b want %b", {pass_a, idmm_a, tsmm_a}, 3'b001); end
    tick();
    ts_val = 32'h58AF95CD;
  endtask

  task automatic test_stall;
    int cyc;
    int unstable;
    stall_len = 10;
    unstable = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 60) begin
      if (wr_a === 1'b1 && (read_a !== 1'b1 || addr_a !== ((cyc <= 11) ? 1'b0 : 1'b1))) unstable++;
      tick();
      cyc++;
    end
    n_cmp++; if (cyc !== 24) begin n_bad++; $display("FAIL stall_latency: got %0d want 24", cyc); end
    n_cmp++; if ({pass_a, to_a} !== 2'b10) begin
      n_bad++; $display("FAIL stall_flags: got %b want %b", {pass_a, to_a}, 2'b10); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL stall_bus_stable: got %0d bad cycles want 0", unstable); end
    tick();
    stall_len = 0;
  endtask

  task automatic test_timeout;
    int cyc;
    bit ts_seen;
    stall_len = 0;
    run_b(20, cyc, ts_seen);
    n_cmp++; if ({cyc == 4, pass_b} !== 2'b11) begin
      n_bad++; $display("FAIL b_zero_wait: got cycle %0d pass %b want cycle 4 pass 1", cyc, pass_b); end
    tick();
    stall_len = 1000;
    id_val = 32'hDEADBEEF;
    run_b(20, cyc, ts_seen);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL to_latency: got %0d want 6", cyc); end
    n_cmp++; if ({to_b, pass_b, ts_seen} !== 3'b100) begin
      n_bad++; $display("FAIL to_flags: got %b want %b (timeout,pass,ts_issued)", {to_b, pass_b, ts_seen}, 3'b100); end
    n_cmp++; if ({capid_b, capts_b} !== {32'hACD51302, 32'h58AF95CD}) begin
      n_bad++; $display("FAIL to_captured: got %h want %h", {capid_b, capts_b}, {32'hACD51302, 32'h58AF95CD}); end
    tick();
    id_val = 32'hACD51302;
    stall_len = 4;
    run_b(30, cyc, ts_seen);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL to_boundary_latency: got %0d want 12", cyc); end
    n_cmp++; if ({to_b, pass_b} !== 2'b01) begin
      n_bad++; $display("FAIL to_boundary_flags: got %b want %b", {to_b, pass_b}, 2'b01); end
    tick();
    stall_len = 0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    n_cmp++; if ({read_a, addr_a} !== 2'b11) begin
      n_bad++; $display("FAIL rst_mid_in_rdts: got %b want %b", {read_a, addr_a}, 2'b11); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a, read_a, addr_a} !== 8'h00) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b want %b", {busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a, read_a, addr_a}, 8'h00); end
    n_cmp++; if ({capid_a, capts_a} !== 64'h0) begin
      n_bad++; $display("FAIL rst_mid_captured: got %h want %h", {capid_a, capts_a}, 64'h0); end
    tick();
    reset_n = 1'b1;
`ifdef SYSID_CHK_AUTOSTART_EN
    wait_auto_a(cyc);
    n_cmp++; if ((done_a === 1'b1 && cyc <= 5) !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_restart: got cycle %0d done %b want done within 5", cyc, done_a); end
`else
    run_a(20, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rst_mid_restart: got %0d want 4", cyc); end
`endif
    n_cmp++; if (pass_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pass: got %b want 1", pass_a); end
    tick();
  endtask

  task automatic test_extra_start;
    int cyc;
    int n_done;
    int first;
    n_done = 0;
    first = 0;
    start_a = 1'b1;
    tick();
    cyc = 1;
    repeat (12) begin
      start_a = (cyc <= 3) ? 1'b1 : 1'b0;
      if (done_a === 1'b1) begin
        n_done++;
        if (first == 0) first = cyc;
      end
      tick();
      cyc++;
    end
    start_a = 1'b0;
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL extra_start_dones: got %0d want 1", n_done); end
    n_cmp++; if (first !== 4) begin n_bad++; $display("FAIL extra_start_latency: got %0d want 4", first); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    id_val = 32'h00000005;
    run_a(20, cyc);
    n_cmp++; if ({pass_a, idmm_a} !== 2'b01) begin
      n_bad++; $display("FAIL b2b_first: got %b want %b", {pass_a, idmm_a}, 2'b01); end
    tick();
    id_val = 32'hACD51302;
    run_a(20, cyc);
    n_cmp++; if ({cyc == 4, pass_a, idmm_a, tsmm_a} !== 4'b1100) begin
      n_bad++; $display("FAIL b2b_second: got cycle %0d flags %b want cycle 4 flags 100", cyc, {pass_a, idmm_a, tsmm_a}); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_zero_wait();
    test_mismatch();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_extra_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Avalon-MM read master that sequences a system-ID slave: reads word 0 (system ID), then word 1 (build timestamp).
- Compares both words against expected values fixed at synthesis; reports pass/fail to HPS-visible status logic and the boot LED driver.
- Sits between the platform reset/boot sequencer and the sysid control slave, on the same clock domain.

Parameters:
- EXPECTED_ID, 32'hACD51302, system ID value required at address 0.
- EXPECTED_TS, 32'h58AF95CD, timestamp value required at address 1.
- TIMEOUT_CYCLES, 255, maximum cycles one read may stall on waitrequest before abort; range 1..65535.
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a check sequence when idle.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence ends (pass, mismatch or timeout).
- pass  out  1  sticky; both words matched on the last sequence.
- id_mismatch  out  1  sticky; word 0 differed from EXPECTED_ID.
- ts_mismatch  out  1  sticky; word 1 differed from EXPECTED_TS.
- timeout  out  1  sticky; a read exceeded TIMEOUT_CYCLES.
- captured_id  out  32  last word read from address 0.
- captured_ts  out  32  last word read from address 1.
- avm_address  out  1  word address to the slave.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave.
- avm_readdata  in  32  read data; valid in the cycle avm_read=1 and avm_waitrequest=0.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, RD_ID, RD_TS, EVAL, FIN.
- IDLE: on start=1, clear pass/id_mismatch/ts_mismatch/timeout, set busy, go to RD_ID next cycle. In any other state, start is ignored.
- RD_ID: drive avm_read=1, avm_address=0.
  - If avm_waitrequest=0: latch captured_id from avm_readdata, go to RD_TS.
  - Otherwise: increment the counter. When the counter reaches TIMEOUT_CYCLES with waitrequest still high, set timeout and go to FIN.
- RD_TS: identical to RD_ID, with avm_address=1 and captured_ts as the latch target. The counter clears on entry.
- Bus rules: avm_read and avm_address are registered and held stable while waitrequest is high. avm_read is low in IDLE, EVAL and FIN. A zero-wait slave completes each read in 1 cycle.
- EVAL: set id_mismatch = (captured_id != EXPECTED_ID), ts_mismatch = (captured_ts != EXPECTED_TS), pass = both equal. Go to FIN.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- Latency, start to done, zero-wait slave: 4 cycles (RD_ID, RD_TS, EVAL, FIN).
- Timeout boundary: waitrequest dropping in the same cycle the counter hits TIMEOUT_CYCLES counts as success; no timeout.
- Timeout path: pass stays 0; only the captured_* words that completed before the abort are updated.
- Reset mid-sequence: immediate abort to reset values. No outstanding transaction is held, since avm_read is forced low.

Optional Feature:
- Macro: SYSID_CHK_AUTOSTART_EN.
- Defined: one internal start fires automatically on the first clock after reset_n deasserts, so the check runs once per boot without software. External start still works afterwards.
- Undefined: the sequence runs only on the start pulse.

Decomposition:
- Package sysid_chk_pkg: FSM state enum, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, default expected-value constants.
- No sub-module needed. An optional small sysid_chk_timer (load/count/expire) is acceptable if reused elsewhere; otherwise keep it inline.

Test Plan:
- Zero-wait slave returning 0xACD51302 / 0x58AF95CD, start pulse -> done at cycle 4, pass=1, mismatch flags 0, captured_ts=0x58AF95CD.
- Slave returns ID 0x00000001 -> id_mismatch=1, ts_mismatch=0, pass=0, captured_id=0x00000001.
- waitrequest high for 10 cycles on each read, TIMEOUT_CYCLES=255 -> done at cycle 24, pass=1, avm_address/avm_read stable during stalls.
- waitrequest stuck high, TIMEOUT_CYCLES=4 -> timeout=1, pass=0, done 1 cycle after expiry, ts read never issued; waitrequest dropping exactly at count 4 -> no timeout.
- Assert reset_n low during RD_TS -> all outputs 0 asynchronously; new start afterward completes normally. Extra start pulses while busy -> ignored, single done.
- With SYSID_CHK_AUTOSTART_EN defined -> sequence runs after reset release with no start, done within 5 cycles.
